// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
// Conditional-execution stage placed directly after the single-cycle main/ALU
// decoder. It holds the architectural NZCV flags and checks the instruction's
// condition field against them. It turns the decoder's write requests into
// committed write strobes, and it keeps saturating executed/skipped counters
// for debug.
//
// Optional feature: define COND_UNDEF_TRAP_EN to make Cond=4'b1111 fail its
// condition and set a sticky undef_o flag. Without the macro, Cond=4'b1111
// behaves as AL and undef_o does not exist.
//
// Parameters
//   CNT_W        width of the exec/skip counters
//   FLAGS_RESET  {N,Z,C,V} value loaded on reset
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   en_i           commit enable (0 = stall)
//   Cond_i[3:0]    instruction condition field
//   ALUFlags_i     {N,Z,C,V} from the ALU this cycle
//   FlagW_i[1:0]   [1] update N,Z   [0] update C,V
//   PCS_i          instruction writes PC
//   RegW_i         instruction writes register file
//   MemW_i         instruction writes data memory
//   BrL_i          branch-with-link, writes R14
//   NoWrite_i      compare-type instruction, suppresses register write
//   PCSrc_o        next-PC select
//   RegWrite_o     register-file write strobe
//   MemWrite_o     data-memory write strobe
//   LinkWrite_o    R14 write strobe
//   CondEx_o       condition passed this cycle
//   Flags_o        registered {N,Z,C,V}
//   ExecCount_o    committed instructions with CondEx=1 (saturating)
//   SkipCount_o    committed instructions with CondEx=0 (saturating)
//   Undef_o        sticky undefined-condition flag (COND_UNDEF_TRAP_EN only)
// -----------------------------------------------------------------------------
module cond_unit #(
    parameter int unsigned CNT_W       = 16,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [3:0]       Cond_i,
    input  logic [3:0]       ALUFlags_i,
    input  logic [1:0]       FlagW_i,
    input  logic             PCS_i,
    input  logic             RegW_i,
    input  logic             MemW_i,
    input  logic             BrL_i,
    input  logic             NoWrite_i,
    output logic             PCSrc_o,
    output logic             RegWrite_o,
    output logic             MemWrite_o,
    output logic             LinkWrite_o,
    output logic             CondEx_o,
    output logic [3:0]       Flags_o,
    output logic [CNT_W-1:0] ExecCount_o,
`ifdef COND_UNDEF_TRAP_EN
    output logic             Undef_o,
`endif
    output logic [CNT_W-1:0] SkipCount_o
);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             n_flag, z_flag, c_flag, v_flag;
    logic             cond_ex;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    // The condition is checked against the registered flags only. A
    // flag-setting instruction therefore never affects its own condition.
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond_i)
            4'h0: cond_ex = z_flag;
            4'h1: cond_ex = ~z_flag;
            4'h2: cond_ex = c_flag;
            4'h3: cond_ex = ~c_flag;
            4'h4: cond_ex = n_flag;
            4'h5: cond_ex = ~n_flag;
            4'h6: cond_ex = v_flag;
            4'h7: cond_ex = ~v_flag;
            4'h8: cond_ex = c_flag & ~z_flag;
            4'h9: cond_ex = ~c_flag | z_flag;
            4'hA: cond_ex = (n_flag == v_flag);
            4'hB: cond_ex = (n_flag != v_flag);
            4'hC: cond_ex = ~z_flag & (n_flag == v_flag);
            4'hD: cond_ex = z_flag | (n_flag != v_flag);
            4'hE: cond_ex = 1'b1;
`ifdef COND_UNDEF_TRAP_EN
            4'hF: cond_ex = 1'b0;
`else
            4'hF: cond_ex = 1'b1;
`endif
            default: cond_ex = 1'b0;
        endcase
    end

    assign CondEx_o = cond_ex;

    // PCSrc ignores en_i because the PC is stalled too. Every strobe is held
    // low while reset is asserted.
    assign PCSrc_o     = PCS_i  & cond_ex & ~reset_i;
    assign RegWrite_o  = RegW_i & cond_ex & ~NoWrite_i & en_i & ~reset_i;
    assign MemWrite_o  = MemW_i & cond_ex & en_i & ~reset_i;
    assign LinkWrite_o = BrL_i  & cond_ex & en_i & ~reset_i;

    always_comb begin
        flags_d = flags_q;
        exec_d  = exec_q;
        skip_d  = skip_q;
        if (en_i) begin
            if (cond_ex) begin
                if (FlagW_i[1]) flags_d[3:2] = ALUFlags_i[3:2];
                if (FlagW_i[0]) flags_d[1:0] = ALUFlags_i[1:0];
                if (exec_q != {CNT_W{1'b1}}) exec_d = exec_q + CNT_W'(1);
            end else begin
                if (skip_q != {CNT_W{1'b1}}) skip_d = skip_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flags_q <= FLAGS_RESET;
            exec_q  <= '0;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            exec_q  <= exec_d;
            skip_q  <= skip_d;
        end
    end

    assign Flags_o     = flags_q;
    assign ExecCount_o = exec_q;
    assign SkipCount_o = skip_q;

`ifdef COND_UNDEF_TRAP_EN
    logic undef_q, undef_d;

    always_comb begin
        undef_d = undef_q;
        if (en_i && (Cond_i == 4'hF)) undef_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) undef_q <= 1'b0;
        else         undef_q <= undef_d;
    end

    assign Undef_o = undef_q;
`endif

endmodule
